// File: rtl/dds_sweep_ctrl.sv
// Linear FTW sweep sequencer for the DDS core: byte-wide register file, shadowed on start, stepping FTW with dwell.
// Latency: outputs registered, one cycle after start/abort/dwell expiry; no backpressure (outputs drive the DDS continuously).
`timescale 1ns/1ps
module dds_sweep_ctrl #(
    parameter int WIDTH   = 6,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   ftw_out,
    output logic [1:0]         wavesel_out,
    output logic [5:0]         amp_out,
    output logic               dds_en,
    output logic               busy,
    output logic               done,
    output logic               sweep_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   reg_start, reg_stop, reg_step;
    logic [DWELL_W-1:0] reg_dwell;
    logic [5:0]         reg_amp;
    logic [3:0]         reg_ctrl;

    logic [WIDTH-1:0]   s_start, s_stop, s_step;
    logic [DWELL_W-1:0] s_dwell;
    logic [5:0]         s_amp;
    logic [1:0]         s_wavesel;
    logic               s_repeat, s_bounce;

    logic [WIDTH-1:0]   ftw_q, ftw_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               leg_q, leg_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic               load_shadow;

    logic               fwd_up, mv_up;
    logic [WIDTH-1:0]   tgt, other;

    // One step toward tgt in WIDTH+1 bits so overflow/borrow clamps to the endpoint.
    function automatic logic [WIDTH-1:0] step_to(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] stp,
        input logic [WIDTH-1:0] dst,
        input logic             up
    );
        logic [WIDTH:0] ext;
        ext = '0;
        if (up) begin
            ext = {1'b0, cur} + {1'b0, stp};
            if (ext > {1'b0, dst}) ext = {1'b0, dst};
        end else begin
            ext = {1'b0, cur} - {1'b0, stp};
            if (ext[WIDTH] || (ext < {1'b0, dst})) ext = {1'b0, dst};
        end
        return ext[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_start <= '0;
            reg_stop  <= '0;
            reg_step  <= '0;
            reg_dwell <= '0;
            reg_amp   <= '0;
            reg_ctrl  <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    reg_start <= cfg_wdata[WIDTH-1:0];
                3'd1:    reg_stop  <= cfg_wdata[WIDTH-1:0];
                3'd2:    reg_step  <= cfg_wdata[WIDTH-1:0];
                3'd3:    reg_dwell <= cfg_wdata[DWELL_W-1:0];
                3'd4:    reg_amp   <= cfg_wdata[5:0];
                3'd5:    reg_ctrl  <= cfg_wdata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_start   <= '0;
            s_stop    <= '0;
            s_step    <= '0;
            s_dwell   <= '0;
            s_amp     <= '0;
            s_wavesel <= '0;
            s_repeat  <= 1'b0;
            s_bounce  <= 1'b0;
        end else if (load_shadow) begin
            s_start   <= reg_start;
            s_stop    <= reg_stop;
            s_step    <= reg_step;
            s_dwell   <= reg_dwell;
            s_amp     <= reg_amp;
            s_wavesel <= reg_ctrl[1:0];
            s_repeat  <= reg_ctrl[2];
            s_bounce  <= reg_ctrl[3];
        end
    end

    // leg_q=0: heading to STOP; leg_q=1: bounce return leg heading to START.
    assign fwd_up = (s_stop >= s_start);
    assign mv_up  = fwd_up ^ leg_q;
    assign tgt    = leg_q ? s_start : s_stop;
    assign other  = leg_q ? s_stop  : s_start;

    always_comb begin
        state_d     = state_q;
        ftw_d       = ftw_q;
        cnt_d       = cnt_q;
        leg_d       = leg_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        load_shadow = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            ftw_d   = '0;
            cnt_d   = '0;
            leg_d   = 1'b0;
        end else if (start && (state_q != ST_RUN)) begin
            state_d     = ST_RUN;
            ftw_d       = reg_start;
            cnt_d       = reg_dwell;
            leg_d       = 1'b0;
            load_shadow = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else begin
                cnt_d = s_dwell;
                if (ftw_q == tgt) begin
                    if (s_bounce) begin
                        leg_d  = ~leg_q;
                        ftw_d  = step_to(ftw_q, s_step, other, ~mv_up);
                        wrap_d = 1'b1;
                    end else if (s_repeat) begin
                        leg_d  = 1'b0;
                        ftw_d  = s_start;
                        wrap_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end else begin
                    ftw_d = step_to(ftw_q, s_step, tgt, mv_up);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ftw_q   <= '0;
            cnt_q   <= '0;
            leg_q   <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ftw_q   <= ftw_d;
            cnt_q   <= cnt_d;
            leg_q   <= leg_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ftw_out     = (state_q == ST_IDLE) ? '0 : ftw_q;
    assign wavesel_out = (state_q == ST_IDLE) ? reg_ctrl[1:0] : s_wavesel;
    assign amp_out     = (state_q == ST_IDLE) ? reg_amp : s_amp;
    assign dds_en      = (state_q != ST_IDLE);
    assign busy        = (state_q == ST_RUN);
    assign done        = done_q;
    assign sweep_wrap  = wrap_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl; stimulus pushes expected per-cycle outputs, monitor compares on negedge.
`timescale 1ns/1ps
module tb_dds_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, cfg_we, start, abort;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [5:0] ftw_out, amp_out;
    logic [1:0] wavesel_out;
    logic       dds_en, busy, done, sweep_wrap;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [15:0] tag;
        logic [5:0]  ftw;
        logic [1:0]  wav;
        logic [5:0]  amp;
        logic        en;
        logic        busy;
        logic        done;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];

    int t2[3]   = '{8, 12, 14};
    int t3[10]  = '{15, 10, 8, 13, 18, 20, 15, 10, 8, 13};
    bit t3w[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int t4[12]  = '{0, 3, 3, 6, 6, 0, 0, 3, 3, 6, 6, 0};
    bit t4w[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int t5a[4]  = '{3, 3, 6, 6};
    int t5b[4]  = '{20, 40, 60, 63};

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.WIDTH(6), .DWELL_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .start       (start),
        .abort       (abort),
        .ftw_out     (ftw_out),
        .wavesel_out (wavesel_out),
        .amp_out     (amp_out),
        .dds_en      (dds_en),
        .busy        (busy),
        .done        (done),
        .sweep_wrap  (sweep_wrap)
    );

    function automatic exp_t mk(input int tag, input int ftw, input int wav, input int amp,
                                input bit en, input bit bsy, input bit dn, input bit wr);
        exp_t e;
        e.tag  = 16'(tag);
        e.ftw  = 6'(ftw);
        e.wav  = 2'(wav);
        e.amp  = 6'(amp);
        e.en   = en;
        e.busy = bsy;
        e.done = dn;
        e.wrap = wr;
        return e;
    endfunction

    // Called at negedge+1; inputs hit the next posedge, expectation is checked at the following negedge.
    task automatic cyc(input logic s, input logic a, input logic w, input logic [2:0] ad,
                       input logic [7:0] d, input logic c, input exp_t e);
        start     = s;
        abort     = a;
        cfg_we    = w;
        cfg_addr  = ad;
        cfg_wdata = d;
        if (c) exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, ad, d, 1'b0, '0);
    endtask

    task automatic chk(input exp_t e);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, e);
    endtask

    task automatic go(input exp_t e);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({ftw_out, wavesel_out, amp_out, dds_en, busy, done, sweep_wrap} !==
                    {e.ftw, e.wav, e.amp, e.en, e.busy, e.done, e.wrap}) begin
                    bad++;
                    $display("FAIL t%0d got ftw=%0d wav=%0d amp=%0d en=%b busy=%b done=%b wrap=%b want ftw=%0d wav=%0d amp=%0d en=%b busy=%b done=%b wrap=%b",
                             e.tag, ftw_out, wavesel_out, amp_out, dds_en, busy, done, sweep_wrap,
                             e.ftw, e.wav, e.amp, e.en, e.busy, e.done, e.wrap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'd0;
        @(negedge clk);
        #1;
        chk(mk(1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        chk(mk(2, 0, 0, 0, 0, 0, 0, 0));

        // single shot 4..16 step 4, dwell 2; amp write exercises upper-bit masking
        wr(3'd0, 8'd4); wr(3'd1, 8'd16); wr(3'd2, 8'd4); wr(3'd3, 8'd2);
        wr(3'd4, 8'hEA); wr(3'd5, 8'h01);
        chk(mk(100, 0, 1, 42, 0, 0, 0, 0));
        go(mk(101, 4, 1, 42, 1, 1, 0, 0));
        for (int i = 1; i < 12; i++) chk(mk(101 + i, 4 + 4 * (i / 3), 1, 42, 1, 1, 0, 0));
        chk(mk(113, 16, 1, 42, 1, 0, 1, 0));
        chk(mk(114, 16, 1, 42, 1, 0, 0, 0));

        // clamp at STOP=14, dwell 0, restart from HOLD
        wr(3'd1, 8'd14); wr(3'd3, 8'd0);
        chk(mk(200, 16, 1, 42, 1, 0, 0, 0));
        go(mk(201, 4, 1, 42, 1, 1, 0, 0));
        for (int i = 0; i < 3; i++) chk(mk(202 + i, t2[i], 1, 42, 1, 1, 0, 0));
        chk(mk(205, 14, 1, 42, 1, 0, 1, 0));
        chk(mk(206, 14, 1, 42, 1, 0, 0, 0));

        // bounce 20 -> 8 step 5; start mid-run is ignored
        wr(3'd0, 8'd20); wr(3'd1, 8'd8); wr(3'd2, 8'd5); wr(3'd5, 8'h0A);
        go(mk(300, 20, 2, 42, 1, 1, 0, 0));
        for (int i = 0; i < 10; i++)
            cyc((i == 4), 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, mk(301 + i, t3[i], 2, 42, 1, 1, 0, t3w[i]));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, mk(320, 0, 2, 42, 0, 0, 0, 0));
        chk(mk(321, 0, 2, 42, 0, 0, 0, 0));

        // repeat 0..6 step 3, dwell 1
        wr(3'd0, 8'd0); wr(3'd1, 8'd6); wr(3'd2, 8'd3); wr(3'd3, 8'd1); wr(3'd5, 8'h04);
        go(mk(400, 0, 0, 42, 1, 1, 0, 0));
        for (int i = 0; i < 12; i++) chk(mk(401 + i, t4[i], 0, 42, 1, 1, 0, t4w[i]));
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, mk(420, 0, 0, 42, 0, 0, 0, 0));

        // mid-sweep STOP write only affects the next start
        wr(3'd5, 8'h00);
        go(mk(500, 0, 0, 42, 1, 1, 0, 0));
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 8'd63, 1'b1, mk(501, 0, 0, 42, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) chk(mk(502 + i, t5a[i], 0, 42, 1, 1, 0, 0));
        chk(mk(506, 6, 0, 42, 1, 0, 1, 0));
        chk(mk(507, 6, 0, 42, 1, 0, 0, 0));
        wr(3'd3, 8'd0); wr(3'd2, 8'd20);
        go(mk(510, 0, 0, 42, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++) chk(mk(511 + i, t5b[i], 0, 42, 1, 1, 0, 0));
        chk(mk(515, 63, 0, 42, 1, 0, 1, 0));
        chk(mk(516, 63, 0, 42, 1, 0, 0, 0));

        // START==STOP with STEP=0: done after the first dwell
        wr(3'd0, 8'd5); wr(3'd1, 8'd5); wr(3'd2, 8'd0);
        go(mk(600, 5, 0, 42, 1, 1, 0, 0));
        chk(mk(601, 5, 0, 42, 1, 0, 1, 0));
        chk(mk(602, 5, 0, 42, 1, 0, 0, 0));

        // reset mid-run clears everything
        wr(3'd0, 8'd0); wr(3'd1, 8'd63); wr(3'd2, 8'd1);
        go(mk(700, 0, 0, 42, 1, 1, 0, 0));
        chk(mk(701, 1, 0, 42, 1, 1, 0, 0));
        chk(mk(702, 2, 0, 42, 1, 1, 0, 0));
        rst_n = 1'b0;
        chk(mk(703, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        chk(mk(704, 0, 0, 0, 0, 0, 0, 0));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
